// File: rtl/bldc_pkg.sv
// ---------------------------------------------------------------------------
// bldc_pkg
// Shared definitions for the brushless_motor_dt commutation driver:
//   - FSM state encodings (OFF, DEAD, DRIVE, LIMIT)
//   - Avalon-MM register addresses
//   - 6-bit gate patterns, ordered {Lau, Lbu, Lcu, Lad, Lbd, Lcd}
//   - commutate(): Hall code + direction -> gate pattern
//   - set_byte(): byte-lane replace used by the multi-byte registers
// ---------------------------------------------------------------------------
package bldc_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_LIMIT = 2'd3;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_WIDTH_LO = 4'd2;
    localparam logic [3:0] ADDR_WIDTH_HI = 4'd5;
    localparam logic [3:0] ADDR_FREQ_LO  = 4'd6;
    localparam logic [3:0] ADDR_FREQ_HI  = 4'd9;
    localparam logic [3:0] ADDR_DEAD     = 4'd10;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'd11;
    localparam logic [3:0] ADDR_HALL     = 4'd12;

    localparam logic [5:0] PAT_OFF   = 6'b000_000;
    localparam logic [5:0] PAT_BRAKE = 6'b000_111;

    // Forward table; reverse rotation simply swaps which side of each
    // phase is driven, so it is the forward pattern with halves exchanged.
    function automatic logic [5:0] commutate(input logic [2:0] hall, input logic fwd);
        logic [5:0] p;
        case (hall)
            3'b100:  p = 6'b100_001;
            3'b110:  p = 6'b010_001;
            3'b010:  p = 6'b010_100;
            3'b011:  p = 6'b001_100;
            3'b001:  p = 6'b001_010;
            3'b101:  p = 6'b100_010;
            default: p = PAT_OFF;
        endcase
        return fwd ? p : {p[2:0], p[5:3]};
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// ---------------------------------------------------------------------------
// bldc_hall_filter
// Synchronises the three asynchronous Hall inputs through two flops and only
// accepts a code once it has been seen for HALL_FILT consecutive clocks.
// Ports:
//   csi_MCLK_clk      in   clock
//   rsi_MRST_reset_n  in   asynchronous active-low reset
//   hall_raw[2:0]     in   raw {Ha, Hb, Hc}
//   hall_code[2:0]    out  last accepted code
//   hall_valid        out  a code has been accepted since reset
// ---------------------------------------------------------------------------
module bldc_hall_filter #(
    parameter int HALL_FILT = 4
) (
    input  logic       csi_MCLK_clk,
    input  logic       rsi_MRST_reset_n,
    input  logic [2:0] hall_raw,
    output logic [2:0] hall_code,
    output logic       hall_valid
);

    localparam int CW = $clog2(HALL_FILT + 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    prime;

    // Number of consecutive clocks (including this one) that sync2 has held
    // the candidate value; saturates at HALL_FILT.
    always_comb begin
        cnt_next = cnt;
        if (sync2 != cand)
            cnt_next = CW'(1);
        else if (cnt < CW'(HALL_FILT))
            cnt_next = cnt + CW'(1);
    end

    // The synchroniser's reset value looks like code 000; prime keeps it from
    // being counted as a real (illegal) Hall code before it has filled.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            sync1      <= 3'b000;
            sync2      <= 3'b000;
            cand       <= 3'b000;
            cnt        <= '0;
            prime      <= 2'b00;
            hall_code  <= 3'b000;
            hall_valid <= 1'b0;
        end else begin
            sync1 <= hall_raw;
            sync2 <= sync1;
            prime <= {prime[0], 1'b1};
            cand  <= sync2;
            if (!prime[1]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
                if (cnt_next >= CW'(HALL_FILT)) begin
                    hall_code  <= sync2;
                    hall_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/brushless_motor_dt.sv
// ---------------------------------------------------------------------------
// brushless_motor_dt
// 3-phase BLDC commutation driver with dead time, cycle-by-cycle current
// limit and sticky illegal-Hall fault, controlled over an 8-bit Avalon-MM bus.
// Ports:
//   csi_MCLK_clk           in   clock
//   rsi_MRST_reset_n       in   asynchronous active-low reset
//   avs_ctrl_address[3:0]  in   register index
//   avs_ctrl_writedata[7:0]in   write data
//   avs_ctrl_write         in   write strobe
//   avs_ctrl_read          in   read strobe
//   avs_ctrl_readdata[7:0] out  registered read data
//   ins_irq_irq            out  level interrupt
//   I_limit                in   overcurrent comparator (async)
//   Ha, Hb, Hc             in   Hall sensors (async)
//   Lau, Lbu, Lcu          out  high-side gate enables
//   Lad, Lbd, Lcd          out  low-side gate enables, PWM-gated
// ---------------------------------------------------------------------------
module brushless_motor_dt
    import bldc_pkg::*;
#(
    parameter int PWM_W     = 32,
    parameter int DT_W      = 8,
    parameter int HALL_FILT = 4
) (
    input  logic       csi_MCLK_clk,
    input  logic       rsi_MRST_reset_n,
    input  logic [3:0] avs_ctrl_address,
    input  logic [7:0] avs_ctrl_writedata,
    input  logic       avs_ctrl_write,
    input  logic       avs_ctrl_read,
    output logic [7:0] avs_ctrl_readdata,
    output logic       ins_irq_irq,
    input  logic       I_limit,
    input  logic       Ha,
    input  logic       Hb,
    input  logic       Hc,
    output logic       Lau,
    output logic       Lbu,
    output logic       Lcu,
    output logic       Lad,
    output logic       Lbd,
    output logic       Lcd
);

    logic [2:0]       ctrl_q;
    logic [1:0]       status_q;
    logic [1:0]       irq_en_q;
    logic [PWM_W-1:0] width_q;
    logic [PWM_W-1:0] freq_q;
    logic [PWM_W-1:0] acc_q;
    logic [DT_W-1:0]  dead_q;
    logic [DT_W-1:0]  dt_cnt;
    logic [1:0]       state;
    logic [5:0]       pattern;
    logic [5:0]       target;
    logic [5:0]       drive;
    logic             pwm_on;
    logic [1:0]       ilim_sync;
    logic             ilim_now;
    logic [2:0]       hall_code;
    logic             hall_valid;
    logic             hall_illegal;
    logic [PWM_W:0]   acc_sum;
    logic             wrap;
    logic [31:0]      width_ext;
    logic [31:0]      freq_ext;
    logic [1:0]       byte_idx;
    logic [1:0]       status_set;
    logic [1:0]       status_clr;
    logic [7:0]       rd_mux;
    logic             fwd;
    logic             brake;
    logic             enable;

    assign fwd    = ctrl_q[0];
    assign brake  = ctrl_q[1];
    assign enable = ctrl_q[2];

    bldc_hall_filter #(.HALL_FILT(HALL_FILT)) u_hall (
        .csi_MCLK_clk     (csi_MCLK_clk),
        .rsi_MRST_reset_n (rsi_MRST_reset_n),
        .hall_raw         ({Ha, Hb, Hc}),
        .hall_code        (hall_code),
        .hall_valid       (hall_valid)
    );

    // Zero-extended 32-bit views give "bytes above PWM_W read 0" for free.
    assign width_ext = 32'(width_q);
    assign freq_ext  = 32'(freq_q);
    assign byte_idx  = (avs_ctrl_address >= ADDR_FREQ_LO)
                     ? 2'(avs_ctrl_address - ADDR_FREQ_LO)
                     : 2'(avs_ctrl_address - ADDR_WIDTH_LO);

    // Control register writes.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            ctrl_q   <= 3'b000;
            irq_en_q <= 2'b00;
            dead_q   <= '0;
            width_q  <= '0;
            freq_q   <= '0;
        end else if (avs_ctrl_write) begin
            if (avs_ctrl_address == ADDR_CTRL)
                ctrl_q <= avs_ctrl_writedata[2:0];
            else if (avs_ctrl_address == ADDR_IRQ_EN)
                irq_en_q <= avs_ctrl_writedata[1:0];
            else if (avs_ctrl_address == ADDR_DEAD)
                dead_q <= DT_W'(avs_ctrl_writedata);
            else if (avs_ctrl_address >= ADDR_WIDTH_LO && avs_ctrl_address <= ADDR_WIDTH_HI)
                width_q <= PWM_W'(set_byte(width_ext, byte_idx, avs_ctrl_writedata));
            else if (avs_ctrl_address >= ADDR_FREQ_LO && avs_ctrl_address <= ADDR_FREQ_HI)
                freq_q <= PWM_W'(set_byte(freq_ext, byte_idx, avs_ctrl_writedata));
        end
    end

    // Sticky status: a persisting fault wins over a same-cycle clear.
    assign hall_illegal = hall_valid && (hall_code == 3'b000 || hall_code == 3'b111);
    assign status_set   = {enable && ilim_now && (state == ST_DRIVE || state == ST_DEAD),
                           hall_illegal};
    assign status_clr   = (avs_ctrl_write && avs_ctrl_address == ADDR_STATUS)
                        ? avs_ctrl_writedata[1:0] : 2'b00;

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n)
            status_q <= 2'b00;
        else
            status_q <= (status_q & ~status_clr) | status_set;
    end

    assign ins_irq_irq = |(status_q & irq_en_q);

    always_comb begin
        rd_mux = 8'h00;
        if (avs_ctrl_address == ADDR_CTRL)
            rd_mux = {5'b0, ctrl_q};
        else if (avs_ctrl_address == ADDR_STATUS)
            rd_mux = {6'b0, status_q};
        else if (avs_ctrl_address >= ADDR_WIDTH_LO && avs_ctrl_address <= ADDR_WIDTH_HI)
            rd_mux = width_ext[{byte_idx, 3'b000} +: 8];
        else if (avs_ctrl_address >= ADDR_FREQ_LO && avs_ctrl_address <= ADDR_FREQ_HI)
            rd_mux = freq_ext[{byte_idx, 3'b000} +: 8];
        else if (avs_ctrl_address == ADDR_DEAD)
            rd_mux = 8'(dead_q);
        else if (avs_ctrl_address == ADDR_IRQ_EN)
            rd_mux = {6'b0, irq_en_q};
        else if (avs_ctrl_address == ADDR_HALL)
            rd_mux = {5'b0, hall_code};
    end

    // A write in the same cycle as a read suppresses the read update.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n)
            avs_ctrl_readdata <= 8'h00;
        else if (!avs_ctrl_write && avs_ctrl_read)
            avs_ctrl_readdata <= rd_mux;
    end

    // PWM phase accumulator; the carry out marks the start of each period.
    assign acc_sum = {1'b0, acc_q} + {1'b0, freq_q};
    assign wrap    = acc_sum[PWM_W];

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            acc_q     <= '0;
            pwm_on    <= 1'b0;
            ilim_sync <= 2'b00;
        end else begin
            acc_q     <= acc_sum[PWM_W-1:0];
            pwm_on    <= (acc_q <= width_q);
            ilim_sync <= {ilim_sync[0], I_limit};
        end
    end

    assign ilim_now = ilim_sync[1];

    // Fault outranks brake, brake outranks the Hall table.
    always_comb begin
        target = PAT_OFF;
        if (hall_valid && !hall_illegal)
            target = brake ? PAT_BRAKE : commutate(hall_code, fwd);
    end

    // Every path back to DRIVE goes through DEAD so no phase ever sees its
    // high and low switch overlap during a pattern change.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state   <= ST_OFF;
            dt_cnt  <= '0;
            pattern <= PAT_OFF;
        end else if (!enable) begin
            state <= ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state   <= ST_DEAD;
                    dt_cnt  <= dead_q;
                    pattern <= target;
                end
                ST_DRIVE: begin
                    if (ilim_now) begin
                        state <= ST_LIMIT;
                    end else if (target != pattern) begin
                        state   <= ST_DEAD;
                        dt_cnt  <= dead_q;
                        pattern <= target;
                    end
                end
                ST_DEAD: begin
                    if (ilim_now) begin
                        state <= ST_LIMIT;
                    end else if (target != pattern) begin
                        dt_cnt  <= dead_q;
                        pattern <= target;
                    end else if (dt_cnt == '0) begin
                        state <= ST_DRIVE;
                    end else begin
                        dt_cnt <= dt_cnt - DT_W'(1);
                    end
                end
                ST_LIMIT: begin
                    if (wrap && !ilim_now) begin
                        state   <= ST_DEAD;
                        dt_cnt  <= dead_q;
                        pattern <= target;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    // Synced overcurrent blanks the gates in the same cycle it appears,
    // one clock before the FSM itself reaches LIMIT.
    assign drive = (state == ST_DRIVE && !ilim_now) ? pattern : PAT_OFF;

    assign Lau = drive[5];
    assign Lbu = drive[4];
    assign Lcu = drive[3];
    assign Lad = drive[2] & pwm_on;
    assign Lbd = drive[1] & pwm_on;
    assign Lcd = drive[0] & pwm_on;

endmodule

// File: tb/tb_brushless_motor_dt.sv
module tb_brushless_motor_dt;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [2:0] hall;
        logic       fwd;
        logic [5:0] exp;
    } com_vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] wdata = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] rdata;
    logic       irq;
    logic       ilim = 1'b0;
    logic       ha = 1'b1, hb = 1'b0, hc = 1'b0;
    logic       lau, lbu, lcu, lad, lbd, lcd;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    reg_vec_t regTable[14];
    com_vec_t comTable[12];

    brushless_motor_dt dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs_ctrl_address   (addr),
        .avs_ctrl_writedata (wdata),
        .avs_ctrl_write     (wr),
        .avs_ctrl_read      (rd),
        .avs_ctrl_readdata  (rdata),
        .ins_irq_irq        (irq),
        .I_limit            (ilim),
        .Ha                 (ha),
        .Hb                 (hb),
        .Hc                 (hc),
        .Lau                (lau),
        .Lbu                (lbu),
        .Lcu                (lcu),
        .Lad                (lad),
        .Lbd                (lbd),
        .Lcd                (lcd)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {lau, lbu, lcu, lad, lbd, lcd};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        checks++;
        if ((lau && lad) || (lbu && lbd) || (lcu && lcd)) begin
            errors++;
            $display("[TB] FAIL shoot-through actual=%b required=no phase both on", outs());
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [2:0] hall);
        {ha, hb, hc} = hall;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic measureTransition(input string name, input logic [5:0] oldp,
                                     input logic [5:0] newp, input int expZeros);
        int n;
        int zeros;
        n = 0;
        while (outs() == oldp && n < 20) begin tick(); n++; end
        checkOutput({name, " change seen"}, 32'(n < 20), 32'd1);
        zeros = 0;
        while (outs() == 6'b0 && zeros < 40) begin tick(); zeros++; end
        checkOutput({name, " dead clocks"}, 32'(zeros), 32'(expZeros));
        checkOutput({name, " new pattern"}, 32'(outs()), 32'(newp));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] d;
        int hiCnt, loCnt, r, n, found;
        logic prev;

        regTable[0]  = '{4'd10, 8'h05, 8'h05};
        regTable[1]  = '{4'd11, 8'hFF, 8'h03};
        regTable[2]  = '{4'd11, 8'h00, 8'h00};
        regTable[3]  = '{4'd2,  8'hAA, 8'hAA};
        regTable[4]  = '{4'd3,  8'hBB, 8'hBB};
        regTable[5]  = '{4'd4,  8'hCC, 8'hCC};
        regTable[6]  = '{4'd5,  8'hDD, 8'hDD};
        regTable[7]  = '{4'd6,  8'h12, 8'h12};
        regTable[8]  = '{4'd9,  8'h34, 8'h34};
        regTable[9]  = '{4'd0,  8'hF8, 8'h00};
        regTable[10] = '{4'd13, 8'h55, 8'h00};
        regTable[11] = '{4'd12, 8'h07, 8'h04};
        regTable[12] = '{4'd1,  8'h00, 8'h00};
        regTable[13] = '{4'd15, 8'hFF, 8'h00};

        comTable[0]  = '{3'b100, 1'b1, 6'b100_001};
        comTable[1]  = '{3'b110, 1'b1, 6'b010_001};
        comTable[2]  = '{3'b010, 1'b1, 6'b010_100};
        comTable[3]  = '{3'b011, 1'b1, 6'b001_100};
        comTable[4]  = '{3'b001, 1'b1, 6'b001_010};
        comTable[5]  = '{3'b101, 1'b1, 6'b100_010};
        comTable[6]  = '{3'b100, 1'b0, 6'b001_100};
        comTable[7]  = '{3'b110, 1'b0, 6'b001_010};
        comTable[8]  = '{3'b010, 1'b0, 6'b100_010};
        comTable[9]  = '{3'b011, 1'b0, 6'b100_001};
        comTable[10] = '{3'b001, 1'b0, 6'b010_001};
        comTable[11] = '{3'b101, 1'b0, 6'b010_100};

        // T1 reset
        applyStimulus(3'b100);
        ticks(3);
        checkOutput("reset outputs", 32'(outs()), 32'd0);
        checkOutput("reset readdata", 32'(rdata), 32'd0);
        checkOutput("reset irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        ticks(10);
        busRead(4'd0, d);
        checkOutput("ctrl after reset", 32'(d), 32'd0);

        // Register file table
        foreach (regTable[i]) begin
            busWrite(regTable[i].addr, regTable[i].wdata);
            busRead(regTable[i].addr, d);
            checkOutput($sformatf("reg addr %0d", regTable[i].addr), 32'(d), 32'(regTable[i].exp));
        end
        checkOutput("irq idle", 32'(irq), 32'd0);

        // T2 forward commutation with DEAD=5
        for (int i = 2; i <= 5; i++) busWrite(4'(i), 8'hFF);
        busWrite(4'd6, 8'h01);
        for (int i = 7; i <= 9; i++) busWrite(4'(i), 8'h00);
        busWrite(4'd0, 8'h05);
        ticks(20);
        checkOutput("T2 start pattern", 32'(outs()), 32'b100_001);
        applyStimulus(3'b110);
        measureTransition("T2", 6'b100_001, 6'b010_001, 6);

        // Commutation tables, both directions
        foreach (comTable[i]) begin
            busWrite(4'd0, {5'b0, 2'b10, comTable[i].fwd});
            applyStimulus(comTable[i].hall);
            ticks(20);
            checkOutput($sformatf("com hall %b fwd %0d", comTable[i].hall, comTable[i].fwd),
                        32'(outs()), 32'(comTable[i].exp));
            busRead(4'd12, d);
            checkOutput("hall readback", 32'(d), 32'(comTable[i].hall));
        end
        busWrite(4'd0, 8'h05);
        applyStimulus(3'b100);
        ticks(20);
        checkOutput("restore pattern", 32'(outs()), 32'b100_001);

        // T4 glitch rejection and illegal Hall
        applyStimulus(3'b111);
        tick();
        applyStimulus(3'b100);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (outs() != 6'b100_001) n++;
        end
        checkOutput("glitch ignored", 32'(n), 32'd0);
        busRead(4'd1, d);
        checkOutput("status after glitch", 32'(d), 32'd0);
        applyStimulus(3'b000);
        ticks(7);
        checkOutput("illegal hall outputs", 32'(outs()), 32'd0);
        busRead(4'd1, d);
        checkOutput("status hall_err", 32'(d), 32'h01);
        checkOutput("irq masked", 32'(irq), 32'd0);
        busWrite(4'd11, 8'h01);
        checkOutput("irq hall_err", 32'(irq), 32'd1);
        applyStimulus(3'b100);
        ticks(20);
        checkOutput("recover pattern", 32'(outs()), 32'b100_001);
        busWrite(4'd1, 8'h01);
        busRead(4'd1, d);
        checkOutput("status cleared", 32'(d), 32'd0);
        checkOutput("irq cleared", 32'(irq), 32'd0);

        // T3 duty: period of 256 clocks, on while top byte <= 0x3F
        busWrite(4'd6, 8'h00);
        busWrite(4'd9, 8'h01);
        busWrite(4'd5, 8'h3F);
        ticks(10);
        hiCnt = 0; loCnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (lau) hiCnt++;
            if (lcd) loCnt++;
        end
        checkOutput("duty low side", 32'(loCnt), 32'd64);
        checkOutput("duty high side", 32'(hiCnt), 32'd256);

        // T5 current limit: align to the period start seen on Lcd
        prev = lcd; found = 0; r = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (lcd && !prev) begin found = 1; r = cycle; end
            prev = lcd;
        end
        checkOutput("limit period sync", 32'(found), 32'd1);
        ticks(100);
        ilim = 1'b1;
        ticks(3);
        ilim = 1'b0;
        checkOutput("limit blanks outputs", 32'(outs()), 32'd0);
        n = 0;
        while (outs() == 6'b0 && n < 400) begin tick(); n++; end
        checkOutput("limit resume clock", 32'(cycle - r), 32'd261);
        checkOutput("limit resume pattern", 32'(outs()), 32'b100_001);
        busRead(4'd1, d);
        checkOutput("status ilim_seen", 32'(d), 32'h02);
        busWrite(4'd11, 8'h03);
        checkOutput("irq ilim", 32'(irq), 32'd1);
        busWrite(4'd1, 8'h02);
        busRead(4'd1, d);
        checkOutput("ilim cleared", 32'(d), 32'd0);

        // T6 brake then disable
        busWrite(4'd5, 8'hFF);
        ticks(10);
        checkOutput("T6 start pattern", 32'(outs()), 32'b100_001);
        busWrite(4'd0, 8'h07);
        measureTransition("brake", 6'b100_001, 6'b000_111, 6);
        busWrite(4'd0, 8'h00);
        tick();
        checkOutput("disable outputs", 32'(outs()), 32'd0);

        // Asynchronous reset mid-operation
        busWrite(4'd0, 8'h05);
        ticks(20);
        checkOutput("pre async reset", 32'(outs()), 32'b100_001);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset outputs", 32'(outs()), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        busRead(4'd0, d);
        checkOutput("ctrl after async reset", 32'(d), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
